// File: rtl/trigger_readout_scheduler.sv
// Trigger readout scheduler: holdoff-window trigger accumulation, event numbering and a readout FIFO.
// Optional build macro DEADTIME_COUNTER_EN adds the saturating deadtime_o veto-cycle counter.
module trigger_readout_scheduler #(
    parameter int unsigned NUM_TRIGGERS   = 4,
    parameter int unsigned DEPTH_LOG2     = 2,
    parameter int unsigned HOLDOFF_CYCLES = 16,
    parameter int unsigned EVNUM_WIDTH    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    event_flag_i,
    input  logic [NUM_TRIGGERS-1:0] trig_flag_i,
    output logic                    rd_valid_o,
    input  logic                    rd_ready_i,
    output logic [EVNUM_WIDTH-1:0]  rd_evnum_o,
    output logic [NUM_TRIGGERS-1:0] rd_trig_o,
    output logic                    veto_o,
    output logic [15:0]             dropped_o
`ifdef DEADTIME_COUNTER_EN
    ,
    output logic [31:0]             deadtime_o
`endif
);

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W   = DEPTH_LOG2 + 1;
    localparam int unsigned HCNT_W  = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam int unsigned ENTRY_W = EVNUM_WIDTH + NUM_TRIGGERS;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_HOLDOFF = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [HCNT_W-1:0]       hcnt_q, hcnt_d;
    logic [NUM_TRIGGERS-1:0] pattern_q, pattern_d;
    logic [EVNUM_WIDTH-1:0]  evnum_q;
    logic                    push_c;
    logic                    drop_c;
    logic [NUM_TRIGGERS-1:0] push_trig_c;
    logic [ENTRY_W-1:0]      push_data_c;

    logic [ENTRY_W-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [CNT_W-1:0]        slots_c;
    logic                    full_c;
    logic                    pop_c;
    logic [ENTRY_W-1:0]      head_d;

    // The in-flight event holds a reserved slot so its push can never overflow.
    assign slots_c     = count_q + CNT_W'(state_q == ST_HOLDOFF);
    assign full_c      = (slots_c == CNT_W'(DEPTH));
    assign veto_o      = (state_q == ST_HOLDOFF) | full_c | ~enable_i;
    assign pop_c       = rd_valid_o & rd_ready_i;
    assign push_trig_c = pattern_q | trig_flag_i;
    assign push_data_c = {evnum_q, push_trig_c};

    // Event acceptance and holdoff sequencing.
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        pattern_d = pattern_q;
        push_c    = 1'b0;
        drop_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (event_flag_i && enable_i) begin
                    if (full_c) begin
                        drop_c = 1'b1;
                    end else begin
                        pattern_d = trig_flag_i;
                        hcnt_d    = HCNT_W'(HOLDOFF_CYCLES - 1);
                        state_d   = ST_HOLDOFF;
                    end
                end
            end
            ST_HOLDOFF: begin
                pattern_d = push_trig_c;
                drop_c    = event_flag_i;
                if (hcnt_q == '0) begin
                    push_c  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    hcnt_d = hcnt_q - HCNT_W'(1);
                end
            end
        endcase
    end

    // Queue occupancy and next head, bypassing a push that lands straight at the head.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        head_d = mem_q[rd_ptr_d];
        if (push_c && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_data_c;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            hcnt_q     <= '0;
            pattern_q  <= '0;
            evnum_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_o <= 1'b0;
            rd_evnum_o <= '0;
            rd_trig_o  <= '0;
            dropped_o  <= '0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            pattern_q <= pattern_d;
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
                evnum_q  <= evnum_q + EVNUM_WIDTH'(1);
            end
            rd_ptr_q                <= rd_ptr_d;
            count_q                 <= count_d;
            rd_valid_o              <= (count_d != '0);
            {rd_evnum_o, rd_trig_o} <= head_d;
            if (drop_c && (dropped_o != 16'hFFFF)) begin
                dropped_o <= dropped_o + 16'd1;
            end
        end
    end

    // Storage needs no reset; occupancy and pointers qualify its contents.
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= push_data_c;
        end
    end

`ifdef DEADTIME_COUNTER_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            deadtime_o <= '0;
        end else if (enable_i && veto_o && (deadtime_o != 32'hFFFF_FFFF)) begin
            deadtime_o <= deadtime_o + 32'd1;
        end
    end
`endif

endmodule
